// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between the snoop arbiter, the two processor cores and main memory.
// The slave modport is the arbiter's view; master is the cores/MM side.
interface snoop_bus_arbiter_if #(
    parameter int AW = 24
) ();
    logic          REQ_A;
    logic          REQ_B;
    logic          RW_A;
    logic          RW_B;
    logic [AW-1:0] ADDR_A;
    logic [AW-1:0] ADDR_B;
    logic          LOCK_A;
    logic          LOCK_B;
    logic          PHITM_A;
    logic          PHITM_B;
    logic          DR;
    logic          GNT_A;
    logic          GNT_B;
    logic          SNOOP_A;
    logic          SNOOP_B;
    logic          WB_A;
    logic          WB_B;
    logic          AR;
    logic [AW-1:0] ADDR_O;
    logic          RW_O;
    logic          DONE_A;
    logic          DONE_B;
    logic          ERR;

    modport slave (
        input  REQ_A, REQ_B, RW_A, RW_B, ADDR_A, ADDR_B, LOCK_A, LOCK_B,
               PHITM_A, PHITM_B, DR,
        output GNT_A, GNT_B, SNOOP_A, SNOOP_B, WB_A, WB_B, AR, ADDR_O, RW_O,
               DONE_A, DONE_B, ERR
    );

    modport master (
        output REQ_A, REQ_B, RW_A, RW_B, ADDR_A, ADDR_B, LOCK_A, LOCK_B,
               PHITM_A, PHITM_B, DR,
        input  GNT_A, GNT_B, SNOOP_A, SNOOP_B, WB_A, WB_B, AR, ADDR_O, RW_O,
               DONE_A, DONE_B, ERR
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Shared-bus arbiter for two processor cores and main memory: round-robin grant
// with atomic lock, snoop of the non-owner cache, write-back of a Modified line
// ahead of the memory access, and DR timeout. All outputs are registered.
module snoop_bus_arbiter #(
    parameter int AW        = 24,
    parameter int SNOOP_CYC = 1,
    parameter int TIMEOUT   = 64
) (
    input logic                SCLK,
    input logic                SRST,
    snoop_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_SNOOP, ST_WB, ST_MEM, ST_DONE} state_t;

    localparam logic [7:0] SN_LAST = 8'(SNOOP_CYC - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    logic          owner_b;
    logic          ptr_b;
    logic [AW-1:0] addr_q;
    logic          rw_q;
    logic [7:0]    cnt;

    logic          gnt_a, gnt_b, snoop_a, snoop_b, wb_a, wb_b;
    logic          ar, rw_o, done_a, done_b, err;
    logic [AW-1:0] addr_o;

    logic          pick_b;
    logic          req_own;
    logic          lock_own;
    logic          phitm_oth;
    logic [AW-1:0] addr_own;
    logic          rw_own;

    // Arbitration choice and owner-relative views of the core inputs
    always_comb begin
        pick_b    = bus.REQ_B && (!bus.REQ_A || ptr_b);
        req_own   = owner_b ? bus.REQ_B  : bus.REQ_A;
        lock_own  = owner_b ? bus.LOCK_B : bus.LOCK_A;
        phitm_oth = owner_b ? bus.PHITM_A : bus.PHITM_B;
        addr_own  = owner_b ? bus.ADDR_B : bus.ADDR_A;
        rw_own    = owner_b ? bus.RW_B   : bus.RW_A;
    end

    // Transaction FSM with registered bus outputs
    always_ff @(posedge SCLK or posedge SRST) begin
        if (SRST) begin
            state   <= ST_IDLE;
            owner_b <= 1'b0;
            ptr_b   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            cnt     <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            snoop_a <= 1'b0;
            snoop_b <= 1'b0;
            wb_a    <= 1'b0;
            wb_b    <= 1'b0;
            ar      <= 1'b0;
            rw_o    <= 1'b0;
            addr_o  <= '0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.REQ_A || bus.REQ_B) begin
                        owner_b <= pick_b;
                        addr_q  <= pick_b ? bus.ADDR_B : bus.ADDR_A;
                        rw_q    <= pick_b ? bus.RW_B : bus.RW_A;
                        gnt_a   <= !pick_b;
                        gnt_b   <= pick_b;
                        snoop_a <= pick_b;
                        snoop_b <= !pick_b;
                        cnt     <= '0;
                        state   <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    if (cnt == SN_LAST) begin
                        snoop_a <= 1'b0;
                        snoop_b <= 1'b0;
                        cnt     <= '0;
                        ar      <= 1'b1;
                        addr_o  <= addr_q;
                        if (phitm_oth) begin
                            wb_a  <= owner_b;
                            wb_b  <= !owner_b;
                            rw_o  <= 1'b1;
                            state <= ST_WB;
                        end else begin
                            rw_o  <= rw_q;
                            state <= ST_MEM;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // WB and MEM share the DR/timeout handling; only DR in WB moves on to MEM
                ST_WB, ST_MEM: begin
                    if (bus.DR && state == ST_WB) begin
                        wb_a  <= 1'b0;
                        wb_b  <= 1'b0;
                        rw_o  <= rw_q;
                        cnt   <= '0;
                        state <= ST_MEM;
                    end else if (bus.DR || cnt == TO_LAST) begin
                        ar     <= 1'b0;
                        rw_o   <= 1'b0;
                        wb_a   <= 1'b0;
                        wb_b   <= 1'b0;
                        done_a <= !owner_b;
                        done_b <= owner_b;
                        err    <= !bus.DR;
                        cnt    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    err    <= 1'b0;
                    if (lock_own && req_own) begin
                        addr_q  <= addr_own;
                        rw_q    <= rw_own;
                        snoop_a <= owner_b;
                        snoop_b <= !owner_b;
                        cnt     <= '0;
                        state   <= ST_SNOOP;
                    end else begin
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                        ptr_b <= !owner_b;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.GNT_A   = gnt_a;
    assign bus.GNT_B   = gnt_b;
    assign bus.SNOOP_A = snoop_a;
    assign bus.SNOOP_B = snoop_b;
    assign bus.WB_A    = wb_a;
    assign bus.WB_B    = wb_b;
    assign bus.AR      = ar;
    assign bus.ADDR_O  = addr_o;
    assign bus.RW_O    = rw_o;
    assign bus.DONE_A  = done_a;
    assign bus.DONE_B  = done_b;
    assign bus.ERR     = err;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Testbench for snoop_bus_arbiter: table of directed transactions, hand-built
// lock and reset sequences, then random transactions against a round-robin model.
module tb_snoop_bus_arbiter;
    localparam int AW        = 24;
    localparam int SNOOP_CYC = 2;
    localparam int TIMEOUT   = 8;

    logic SCLK = 1'b0;
    logic SRST;

    snoop_bus_arbiter_if #(.AW(AW)) bus ();

    snoop_bus_arbiter #(.AW(AW), .SNOOP_CYC(SNOOP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .SCLK (SCLK),
        .SRST (SRST),
        .bus  (bus)
    );

    // Free-running clock
    always #5 SCLK = ~SCLK;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  m_ptr_b;

    logic [10:0] act_vec;
    assign act_vec = {bus.GNT_A, bus.GNT_B, bus.SNOOP_A, bus.SNOOP_B, bus.WB_A, bus.WB_B,
                      bus.AR, bus.RW_O, bus.DONE_A, bus.DONE_B, bus.ERR};

    typedef struct {
        bit            ra, rb, rwa, rwb;
        logic [AW-1:0] aa, ab;
        bit            hitm;
        int            dwb, dm;
        bit            exp_b;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output vector: grant/done go to the owner, snoop/wb to the other core
    function automatic logic [10:0] ev(bit ob, bit gnt, bit snp, bit wb, bit ar, bit rw,
                                       bit dn, bit er);
        return {gnt & !ob, gnt & ob, snp & ob, snp & !ob, wb & ob, wb & !ob,
                ar, rw, dn & !ob, dn & ob, er};
    endfunction

    function automatic bit arb(bit ra, bit rb);
        return (ra && rb) ? m_ptr_b : rb;
    endfunction

    task automatic tick;
        @(negedge SCLK);
    endtask

    // One AR phase: DR returned d cycles after AR, or never when d >= TIMEOUT
    task automatic phase(input string nm, input bit ob, input bit exp_rw, input bit exp_wb,
                         input logic [AW-1:0] addr, input int d, output bit to);
        int n;
        to = (d >= TIMEOUT);
        n  = to ? TIMEOUT : d + 1;
        for (int c = 0; c < n; c++) begin
            check({nm, "_vec"}, act_vec, ev(ob, 1, 0, exp_wb, 1, exp_rw, 0, 0));
            check({nm, "_addr"}, 32'(bus.ADDR_O), 32'(addr));
            if (!to && c == d) bus.DR = 1'b1;
            tick;
            bus.DR = 1'b0;
        end
    endtask

    // Runs from the first SNOOP cycle to the DONE cycle (inclusive)
    task automatic serve(input bit ob, input bit rw, input logic [AW-1:0] addr, input bit hitm,
                         input int dwb, input int dm, input bit noise, input bit drop);
        bit to;
        for (int k = 0; k < SNOOP_CYC; k++) begin
            check("snoop", act_vec, ev(ob, 1, 1, 0, 0, 0, 0, 0));
            if (noise && k == 0) bus.DR = 1'b1;
            if (k == SNOOP_CYC - 1) begin
                if (ob) begin bus.PHITM_A = hitm; bus.PHITM_B = !hitm; end
                else    begin bus.PHITM_B = hitm; bus.PHITM_A = !hitm; end
            end
            tick;
            bus.DR = 1'b0;
        end
        bus.PHITM_A = 1'b0;
        bus.PHITM_B = 1'b0;
        if (drop) begin
            if (ob) bus.REQ_B = 1'b0; else bus.REQ_A = 1'b0;
        end
        to = 1'b0;
        if (hitm) phase("wb", ob, 1'b1, 1'b1, addr, dwb, to);
        if (!to) phase("mem", ob, rw, 1'b0, addr, dm, to);
        check("done", act_vec, ev(ob, 1, 0, 0, 0, 0, 1, to));
    endtask

    task automatic finish_txn(input bit ob);
        if (ob) bus.REQ_B = 1'b0; else bus.REQ_A = 1'b0;
        bus.LOCK_A = 1'b0;
        bus.LOCK_B = 1'b0;
        m_ptr_b = !ob;
        tick;
        check("idle", act_vec, 11'd0);
    endtask

    task automatic run_from_idle(input bit ob, input bit ra, input bit rb, input bit rwa,
                                 input bit rwb, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                                 input bit hitm, input int dwb, input int dm,
                                 input bit noise, input bit drop);
        bus.REQ_A  = ra;
        bus.REQ_B  = rb;
        bus.RW_A   = rwa;
        bus.RW_B   = rwb;
        bus.ADDR_A = aa;
        bus.ADDR_B = ab;
        bus.LOCK_A = 1'b0;
        bus.LOCK_B = 1'b0;
        tick;
        serve(ob, ob ? rwb : rwa, ob ? ab : aa, hitm, dwb, dm, noise, drop);
        finish_txn(ob);
    endtask

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus and checking sequence
    initial begin
        bit ra, rb, ob;
        bit [3:0] lk_rw;
        tbl[0] = '{1, 1, 0, 1, 24'h000100, 24'h000200, 0, 0, 2, 0};
        tbl[1] = '{0, 1, 0, 1, 24'h000000, 24'h00ABCD, 1, 1, 0, 1};
        tbl[2] = '{1, 1, 1, 0, 24'h123456, 24'h654321, 1, 3, TIMEOUT - 1, 0};
        tbl[3] = '{0, 1, 0, 0, 24'h000000, 24'hFFFFFF, 0, 0, TIMEOUT, 1};
        tbl[4] = '{1, 0, 0, 0, 24'h000000, 24'h000000, 1, TIMEOUT, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 24'h111111, 24'h222222, 0, 0, 0, 1};
        tbl[6] = '{1, 0, 1, 0, 24'hABCDEF, 24'h000000, 0, 0, 0, 0};

        SRST = 1'b1;
        bus.REQ_A = 0; bus.REQ_B = 0; bus.RW_A = 0; bus.RW_B = 0;
        bus.ADDR_A = '0; bus.ADDR_B = '0; bus.LOCK_A = 0; bus.LOCK_B = 0;
        bus.PHITM_A = 0; bus.PHITM_B = 0; bus.DR = 0;
        m_ptr_b = 1'b0;
        tick;
        check("reset_vec", act_vec, 11'd0);
        check("reset_addr", 32'(bus.ADDR_O), 32'd0);
        SRST = 1'b0;
        tick;
        bus.DR = 1'b1;
        tick;
        bus.DR = 1'b0;
        check("dr_in_idle", act_vec, 11'd0);
        tick;
        check("dr_in_idle2", act_vec, 11'd0);

        for (int i = 0; i < 7; i++) begin
            run_from_idle(tbl[i].exp_b, tbl[i].ra, tbl[i].rb, tbl[i].rwa, tbl[i].rwb,
                          tbl[i].aa, tbl[i].ab, tbl[i].hitm, tbl[i].dwb, tbl[i].dm, 0, 0);
        end

        // Locked A: three back-to-back transactions while B waits
        lk_rw = 4'b0101;
        bus.REQ_A = 1; bus.LOCK_A = 1; bus.REQ_B = 0;
        bus.ADDR_A = 24'h0A0000; bus.RW_A = lk_rw[0];
        tick;
        for (int i = 0; i < 3; i++) begin
            serve(1'b0, lk_rw[i], 24'h0A0000 + 24'(i), i == 1, 1, 1, 0, 0);
            bus.REQ_B = 1; bus.ADDR_B = 24'h0B0000; bus.RW_B = 0;
            if (i < 2) begin
                bus.ADDR_A = 24'h0A0000 + 24'(i + 1);
                bus.RW_A   = lk_rw[i + 1];
                tick;
            end
        end
        finish_txn(1'b0);
        run_from_idle(1'b1, 0, 1, 0, 0, 24'h0, 24'h0B0000, 0, 0, 1, 0, 0);

        // Reset while the write-back phase is active
        bus.REQ_A = 0; bus.REQ_B = 1; bus.RW_B = 1; bus.ADDR_B = 24'h00ABCD;
        tick;
        for (int k = 0; k < SNOOP_CYC; k++) begin
            check("rst_snoop", act_vec, ev(1, 1, 1, 0, 0, 0, 0, 0));
            if (k == SNOOP_CYC - 1) bus.PHITM_A = 1'b1;
            tick;
        end
        bus.PHITM_A = 1'b0;
        check("rst_wb", act_vec, ev(1, 1, 0, 1, 1, 1, 0, 0));
        tick;
        #2;
        SRST = 1'b1;
        bus.REQ_B = 1'b0;
        #1;
        check("rst_async_vec", act_vec, 11'd0);
        check("rst_async_addr", 32'(bus.ADDR_O), 32'd0);
        tick;
        SRST = 1'b0;
        m_ptr_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("rst_no_done", act_vec, 11'd0);
        end
        run_from_idle(1'b0, 1, 1, 0, 0, 24'h000ABC, 24'h000DEF, 0, 0, 0, 0, 0);

        // Random transactions against the round-robin model
        for (int n = 0; n < 40; n++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            ob = arb(ra, rb);
            run_from_idle(ob, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, TIMEOUT + 1)),
                          int'($urandom_range(0, TIMEOUT + 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
